instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_mem.sv | 35 +++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding,
// default geometry and the all-zero HALT word.
package instr_fetch_unit_pkg;

   localparam int DEF_INSTR_WIDTH = 20;
   localparam int DEF_ADDR_BITS   = 5;
   localparam int HOLD_W          = 4;

   localparam logic [DEF_INSTR_WIDTH-1:0] HALT_WORD = '0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_DONE  = 2'd3
   } fsm_state_e;

endpackage

// File: rtl/instr_fetch_unit_mem.sv
// Program memory: synchronous write port, registered read with write-first
// forwarding so a word written on the same edge as its read is seen immediately.
module instr_mem
   import instr_fetch_unit_pkg::*;
#(
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
   input  logic                   clk_i,
   input  logic                   we_i,
   input  logic [ADDR_BITS-1:0]   wr_addr_i,
   input  logic [INSTR_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_BITS-1:0]   rd_addr_i,
   output logic [INSTR_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
   logic [INSTR_WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (we_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_q <= wr_data_i;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: steps through program memory from address 0, holding
// each non-zero word on the CPU instruction bus for HOLD_CYCLES cycles.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
   parameter int ADDR_BITS   = DEF_ADDR_BITS,
   parameter int HOLD_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   prog_we,
   input  logic [ADDR_BITS-1:0]   prog_addr,
   input  logic [INSTR_WIDTH-1:0] prog_data,
   input  logic                   start,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_valid,
   output logic [ADDR_BITS-1:0]   pc,
   output logic                   busy,
   output logic                   done
);

   localparam logic [ADDR_BITS-1:0] PC_LAST   = '1;
   localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   fsm_state_e             state_q, state_d;
   logic [ADDR_BITS-1:0]   pc_q, pc_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [INSTR_WIDTH-1:0] fetch_q, fetch_d;
   logic [INSTR_WIDTH-1:0] mem_rd_data;
   logic                   idle_or_done;
   logic                   mem_we;
   logic                   fetched_halt;

   assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign mem_we       = prog_we && idle_or_done;
   assign fetched_halt = (mem_rd_data == INSTR_WIDTH'(HALT_WORD));

   // Read address follows next-state pc, so the word for pc is ready during FETCH.
   instr_mem #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .ADDR_BITS   (ADDR_BITS)
   ) u_mem (
      .clk_i     (clk),
      .we_i      (mem_we),
      .wr_addr_i (prog_addr),
      .wr_data_i (prog_data),
      .rd_addr_i (pc_d),
      .rd_data_o (mem_rd_data)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      fetch_d = fetch_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end
         ST_FETCH: begin
            fetch_d = mem_rd_data;
            hold_d  = '0;
            state_d = fetched_halt ? ST_DONE : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (hold_q == HOLD_LAST) begin
               hold_d = '0;
               if (pc_q == PC_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = ST_FETCH;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         hold_q  <= '0;
         fetch_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         fetch_q <= fetch_d;
      end
   end

   // Outputs decode straight from state so reset clears them without waiting for a clock.
   assign instr_valid = (state_q == ST_ISSUE);
   assign instruction = instr_valid ? fetch_q : '0;
   assign pc          = pc_q;
   assign busy        = (state_q == ST_FETCH) || (state_q == ST_ISSUE);
   assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table for a short program plus
// hand sequences for full-memory run, dropped writes, reset abort and HOLD_CYCLES=1.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   localparam int IW    = 20;
   localparam int AB    = 5;
   localparam int DEPTH = 32;
   localparam int NVEC  = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, prog_we, start;
   logic [AB-1:0] prog_addr;
   logic [IW-1:0] prog_data;
   logic [IW-1:0] instruction;
   logic          instr_valid, busy, done;
   logic [AB-1:0] pc;

   logic          rst1, prog_we1, start1;
   logic [AB-1:0] prog_addr1;
   logic [IW-1:0] prog_data1;
   logic [IW-1:0] instruction1;
   logic          instr_valid1, busy1, done1;
   logic [AB-1:0] pc1;

   instr_fetch_unit #(.INSTR_WIDTH(IW), .ADDR_BITS(AB), .HOLD_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .instruction(instruction),
      .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
   );

   instr_fetch_unit #(.INSTR_WIDTH(IW), .ADDR_BITS(AB), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst1), .prog_we(prog_we1), .prog_addr(prog_addr1),
      .prog_data(prog_data1), .start(start1), .instruction(instruction1),
      .instr_valid(instr_valid1), .pc(pc1), .busy(busy1), .done(done1)
   );

   typedef struct {
      logic          start;
      logic [IW-1:0] instr;
      logic          vld;
      logic [AB-1:0] pc;
      logic          busy;
      logic          done;
   } vec_t;

   vec_t          tbl [NVEC];
   logic [IW-1:0] model [DEPTH];
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] obs();
      return 64'({instruction, instr_valid, pc, busy, done});
   endfunction

   function automatic logic [63:0] obs1();
      return 64'({instruction1, instr_valid1, pc1, busy1, done1});
   endfunction

   function automatic logic [63:0] ex(input logic [IW-1:0] i, input logic v,
                                      input logic [AB-1:0] p, input logic b, input logic d);
      return 64'({i, v, p, b, d});
   endfunction

   function automatic vec_t mk(input logic s, input logic [IW-1:0] i, input logic v,
                               input logic [AB-1:0] p, input logic b, input logic d);
      vec_t t;
      t.start = s; t.instr = i; t.vld = v; t.pc = p; t.busy = b; t.done = d;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [IW-1:0] d);
      prog_we = 1'b1; prog_addr = AB'(a); prog_data = d;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic wr1(input int a, input logic [IW-1:0] d);
      prog_we1 = 1'b1; prog_addr1 = AB'(a); prog_data1 = d;
      tick();
      prog_we1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   issues;
      logic wrapped, seen_nonzero, prev_vld, timed_out;

      // Short program: 3 issues of 4-cycle period, then HALT at address 3.
      tbl[0]  = mk(1'b1, 20'h0,     1'b0, 5'd0, 1'b1, 1'b0);
      tbl[1]  = mk(1'b0, 20'h47000, 1'b1, 5'd0, 1'b1, 1'b0);
      tbl[2]  = mk(1'b0, 20'h47000, 1'b1, 5'd0, 1'b1, 1'b0);
      tbl[3]  = mk(1'b0, 20'h47000, 1'b1, 5'd0, 1'b1, 1'b0);
      tbl[4]  = mk(1'b0, 20'h0,     1'b0, 5'd1, 1'b1, 1'b0);
      tbl[5]  = mk(1'b0, 20'h53000, 1'b1, 5'd1, 1'b1, 1'b0);
      tbl[6]  = mk(1'b1, 20'h53000, 1'b1, 5'd1, 1'b1, 1'b0);
      tbl[7]  = mk(1'b0, 20'h53000, 1'b1, 5'd1, 1'b1, 1'b0);
      tbl[8]  = mk(1'b0, 20'h0,     1'b0, 5'd2, 1'b1, 1'b0);
      tbl[9]  = mk(1'b0, 20'h72001, 1'b1, 5'd2, 1'b1, 1'b0);
      tbl[10] = mk(1'b0, 20'h72001, 1'b1, 5'd2, 1'b1, 1'b0);
      tbl[11] = mk(1'b0, 20'h72001, 1'b1, 5'd2, 1'b1, 1'b0);
      tbl[12] = mk(1'b0, 20'h0,     1'b0, 5'd3, 1'b1, 1'b0);
      tbl[13] = mk(1'b0, 20'h0,     1'b0, 5'd3, 1'b0, 1'b1);
      tbl[14] = mk(1'b0, 20'h0,     1'b0, 5'd3, 1'b0, 1'b1);

      rst = 1'b1; prog_we = 1'b0; start = 1'b0; prog_addr = '0; prog_data = '0;
      rst1 = 1'b1; prog_we1 = 1'b0; start1 = 1'b0; prog_addr1 = '0; prog_data1 = '0;
      tick(); tick();
      check("reset_outputs", obs(), 64'd0);
      rst = 1'b0; rst1 = 1'b0;
      tick();

      for (int i = 0; i < DEPTH; i++) begin
         model[i] = IW'(32'h10001 + 32'(i) * 32'h111);
         wr(i, model[i]);
      end

      // Write and start in the same IDLE cycle: first issue must see the new word.
      prog_we = 1'b1; prog_addr = '0; prog_data = 20'hD80F0; start = 1'b1;
      tick();
      prog_we = 1'b0; start = 1'b0;
      model[0] = 20'hD80F0;
      check("fetch_after_start", obs(), ex(20'h0, 1'b0, 5'd0, 1'b1, 1'b0));
      tick();
      check("same_cycle_write_issue", obs(), ex(20'hD80F0, 1'b1, 5'd0, 1'b1, 1'b0));
      tick();
      check("second_issue_cycle", obs(), ex(20'hD80F0, 1'b1, 5'd0, 1'b1, 1'b0));

      // Asynchronous reset in the middle of the 2nd ISSUE cycle.
      #2 rst = 1'b1;
      #1 check("async_reset_outputs", obs(), 64'd0);
      tick();
      rst = 1'b0;
      tick(); tick();
      check("idle_after_reset", obs(), 64'd0);

      // Full-memory run from address 0; a write attempt during ISSUE of address 0 is dropped.
      start = 1'b1;
      tick();
      start = 1'b0;
      issues = 0; wrapped = 1'b0; seen_nonzero = 1'b0; prev_vld = 1'b0; timed_out = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc == 2) begin
            prog_we = 1'b1; prog_addr = 5'd1; prog_data = 20'hABCDE;
         end else begin
            prog_we = 1'b0;
         end
         tick();
         if (instr_valid && !prev_vld) begin
            check($sformatf("issue_word_%0d", issues), 64'(instruction), 64'(model[pc]));
            check($sformatf("issue_pc_%0d", issues), 64'(pc), 64'(issues));
            issues++;
         end
         if (busy && pc != '0) seen_nonzero = 1'b1;
         if (busy && seen_nonzero && pc == '0) wrapped = 1'b1;
         prev_vld = instr_valid;
         if (done) begin
            timed_out = 1'b0;
            break;
         end
      end
      prog_we = 1'b0;
      check("full_run_timeout", 64'(timed_out), 64'd0);
      check("full_run_issues", 64'(issues), 64'd32);
      check("full_run_no_wrap", 64'(wrapped), 64'd0);
      check("full_run_done_state", obs(), ex(20'h0, 1'b0, 5'd31, 1'b0, 1'b1));

      // Short program with HALT, loaded while DONE.
      wr(0, 20'h47000);
      wr(1, 20'h53000);
      wr(2, 20'h72001);
      wr(3, 20'h00000);
      check("done_held_during_writes", obs(), ex(20'h0, 1'b0, 5'd31, 1'b0, 1'b1));
      for (int r = 0; r < NVEC; r++) begin
         start = tbl[r].start;
         tick();
         check($sformatf("vec_%0d", r), obs(),
               ex(tbl[r].instr, tbl[r].vld, tbl[r].pc, tbl[r].busy, tbl[r].done));
      end
      start = 1'b0;

      // HOLD_CYCLES = 1 instance.
      wr1(0, 20'h47000);
      wr1(1, 20'h00000);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("h1_fetch0", obs1(), ex(20'h0, 1'b0, 5'd0, 1'b1, 1'b0));
      tick();
      check("h1_issue0", obs1(), ex(20'h47000, 1'b1, 5'd0, 1'b1, 1'b0));
      tick();
      check("h1_fetch1", obs1(), ex(20'h0, 1'b0, 5'd1, 1'b1, 1'b0));
      tick();
      check("h1_done", obs1(), ex(20'h0, 1'b0, 5'd1, 1'b0, 1'b1));
      tick();
      check("h1_done_held", obs1(), ex(20'h0, 1'b0, 5'd1, 1'b0, 1'b1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
